// File: rtl/byte_parity_pkg.sv
// Shared constants for the byte_parity controller: FSM state encoding and parameter defaults.
package byte_parity_pkg;
  localparam int BP_DATA_WIDTH = 8;
  localparam int BP_LEN_W      = 8;
  localparam int BP_TIMEOUT    = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_START  = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_OUTPUT = 3'd4;
endpackage

// File: rtl/bpc_timeout_timer.sv
// WAIT-state watchdog (built only with BPC_TIMEOUT_EN): load clears, count while en,
// expire is high on the TIMEOUT-th consecutive counted cycle; no backpressure.
`ifdef BPC_TIMEOUT_EN
module bpc_timeout_timer import byte_parity_pkg::*; #(
  parameter int TIMEOUT = BP_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + CW'(1);
    end
  end

  assign expire = en && (count == CW'(TIMEOUT - 1));
endmodule
`endif

// File: rtl/byte_parity_ctrl.sv
// Burst sequencer for one byte_parity datapath; min 4-cycle pair latency, out_valid/out_parity held under
// out_ready backpressure, only FETCH accepts operands. BPC_TIMEOUT_EN adds a watchdog on the datapath wait.
module byte_parity_ctrl import byte_parity_pkg::*; #(
  parameter int DATA_WIDTH = BP_DATA_WIDTH,
  parameter int LEN_W      = BP_LEN_W
`ifdef BPC_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = BP_TIMEOUT
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [LEN_W-1:0]      req_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  output logic [DATA_WIDTH-1:0] dp_byte_a,
  output logic [DATA_WIDTH-1:0] dp_byte_b,
  output logic                  dp_start,
  input  logic                  dp_done,
  input  logic [DATA_WIDTH-1:0] dp_parity,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_parity,
  output logic                  out_last,
  output logic                  burst_done,
  output logic [DATA_WIDTH-1:0] burst_checksum,
  output logic                  err_timeout,
  output logic                  busy
);
  logic [2:0]       state;
  logic [LEN_W-1:0] remaining;
  logic             last_pair;
  logic             timeout_hit;

  assign req_ready = (state == ST_IDLE);
  assign in_ready  = (state == ST_FETCH);
  assign dp_start  = (state == ST_START);
  assign busy      = (state != ST_IDLE);
  assign last_pair = (remaining == LEN_W'(1));

`ifdef BPC_TIMEOUT_EN
  logic err_q;

  bpc_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (state == ST_START),
    .en     (state == ST_WAIT),
    .expire (timeout_hit)
  );

  // dp_done on the terminal-count cycle is a normal completion, so it masks the abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == ST_IDLE && req_valid) begin
      err_q <= 1'b0;
    end else if (state == ST_WAIT && !dp_done && timeout_hit) begin
      err_q <= 1'b1;
    end
  end

  assign err_timeout = err_q;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      remaining      <= '0;
      dp_byte_a      <= '0;
      dp_byte_b      <= '0;
      out_valid      <= 1'b0;
      out_parity     <= '0;
      out_last       <= 1'b0;
      burst_done     <= 1'b0;
      burst_checksum <= '0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            burst_checksum <= '0;
            remaining      <= req_len;
            if (req_len == '0) begin
              burst_done <= 1'b1;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (in_valid) begin
            dp_byte_a <= in_a;
            dp_byte_b <= in_b;
            state     <= ST_START;
          end
        end
        ST_START: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dp_done) begin
            out_parity <= dp_parity;
            out_valid  <= 1'b1;
            out_last   <= last_pair;
            state      <= ST_OUTPUT;
          end else if (timeout_hit) begin
            // Abort drops the pair in flight and everything still pending in the burst.
            remaining  <= '0;
            burst_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            burst_checksum <= burst_checksum ^ out_parity;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            if (remaining != '0) begin
              remaining <= remaining - LEN_W'(1);
            end
            if (remaining <= LEN_W'(1)) begin
              burst_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              state <= ST_FETCH;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_byte_parity_ctrl.sv
// Randomized bench for byte_parity_ctrl: a transaction-level model checks every cycle,
// directed bursts pin the model with hand-computed literals.
module tb_byte_parity_ctrl;
  import byte_parity_pkg::*;

  localparam int TO = BP_TIMEOUT;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_len = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = 8'd0;
  logic [7:0] in_b = 8'd0;
  logic [7:0] dp_byte_a, dp_byte_b;
  logic       dp_start;
  logic       dp_done = 1'b0;
  logic [7:0] dp_parity = 8'd0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_parity;
  logic       out_last, burst_done;
  logic [7:0] burst_checksum;
  logic       err_timeout, busy;

  byte_parity_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dp_byte_a(dp_byte_a), .dp_byte_b(dp_byte_b), .dp_start(dp_start),
    .dp_done(dp_done), .dp_parity(dp_parity),
    .out_valid(out_valid), .out_ready(out_ready), .out_parity(out_parity),
    .out_last(out_last), .burst_done(burst_done), .burst_checksum(burst_checksum),
    .err_timeout(err_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Datapath stand-in: parity = a^b after dp_lat cycles (1 = done in the cycle after start).
  int   dp_lat_fixed = 1;
  bit   dp_hang = 0;
  bit   noise_en = 0;
  int   dp_cnt = 0;
  bit   dp_pend = 0;
  logic [7:0] dp_res = 8'd0;

  always @(posedge clk or posedge reset) begin : dp_model
    int lat;
    if (reset) begin
      dp_done <= 1'b0;
      dp_pend <= 1'b0;
      dp_cnt  <= 0;
    end else begin
      dp_done <= 1'b0;
      if (dp_start && !dp_hang) begin
        lat = (dp_lat_fixed > 0) ? dp_lat_fixed : int'($urandom_range(1, 4));
        if (lat == 1) begin
          dp_done   <= 1'b1;
          dp_parity <= dp_byte_a ^ dp_byte_b;
        end else begin
          dp_pend <= 1'b1;
          dp_cnt  <= lat - 1;
          dp_res  <= dp_byte_a ^ dp_byte_b;
        end
      end else if (dp_pend) begin
        if (dp_cnt <= 1) begin
          dp_done   <= 1'b1;
          dp_parity <= dp_res;
          dp_pend   <= 1'b0;
        end else begin
          dp_cnt <= dp_cnt - 1;
        end
      end else if (noise_en && (in_ready || req_ready || out_valid) && $urandom_range(0, 3) == 0) begin
        dp_done   <= 1'b1;
        dp_parity <= 8'($urandom);
      end
    end
  end

  // Transaction-level model: burst bookkeeping, expected-parity queue, running checksum.
  logic [7:0] exp_q[$];
  logic [8:0] obs_q[$];
  int   m_len = 0, m_acc = 0, m_out = 0, wcnt = 0;
  bit   m_active = 0, st_exp = 0, p_wait = 0, ov_exp = 0, done_exp = 0, err_exp = 0;
  logic [7:0] m_sum = 8'd0, la = 8'd0, lb = 8'd0;
  int   n_start = 0, n_done = 0, n_ov = 0, last_start_cyc = 0;

  always @(negedge clk) begin : compare
    bit st_nx;
    if (reset) begin
      chk("rst_req_ready", 32'(req_ready), 32'(1));
      chk("rst_ctrl", 32'({in_ready, dp_start, out_valid, out_last, burst_done, err_timeout, busy}), 32'(0));
      chk("rst_data", {dp_byte_a, dp_byte_b, out_parity, burst_checksum}, 32'(0));
      exp_q.delete();
      m_len = 0; m_acc = 0; m_out = 0; wcnt = 0;
      m_active = 0; st_exp = 0; p_wait = 0; ov_exp = 0; done_exp = 0; err_exp = 0;
      m_sum = 8'd0;
    end else begin
      chk("req_ready", 32'(req_ready), 32'(!m_active));
      chk("busy", 32'(busy), 32'(m_active));
      chk("in_ready", 32'(in_ready), 32'(m_active && m_acc == m_out));
      chk("dp_start", 32'(dp_start), 32'(st_exp));
      chk("out_valid", 32'(out_valid), 32'(ov_exp));
      chk("burst_done", 32'(burst_done), 32'(done_exp));
      chk("err_timeout", 32'(err_timeout), 32'(err_exp));
      chk("checksum", 32'(burst_checksum), 32'(m_sum));
      if (st_exp || p_wait) chk("operands", 32'({dp_byte_a, dp_byte_b}), 32'({la, lb}));
      if (ov_exp && exp_q.size() > 0) begin
        chk("out_parity", 32'(out_parity), 32'(exp_q[0]));
        chk("out_last", 32'(out_last), 32'(m_out + 1 == m_len));
      end
      if (dp_start) begin n_start++; last_start_cyc = cyc; end
      if (burst_done) n_done++;
      if (out_valid) n_ov++;

      done_exp = 0;
      st_nx = 0;
      if (!m_active && req_valid) begin
        m_sum = 8'd0; err_exp = 0; m_len = int'(req_len); m_acc = 0; m_out = 0;
        m_active = (req_len != 8'd0);
        done_exp = (req_len == 8'd0);
        exp_q.delete();
      end else if (m_active && m_acc == m_out && !st_exp && !p_wait && !ov_exp && in_valid) begin
        exp_q.push_back(in_a ^ in_b);
        la = in_a; lb = in_b;
        m_acc++;
        st_nx = 1;
      end else if (p_wait) begin
        if (dp_done) begin
          ov_exp = 1;
          p_wait = 0;
        end else begin
          wcnt++;
`ifdef BPC_TIMEOUT_EN
          if (wcnt == TO) begin
            p_wait = 0; m_active = 0; err_exp = 1; done_exp = 1;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
`endif
        end
      end else if (ov_exp && out_ready) begin
        obs_q.push_back({out_last, out_parity});
        if (exp_q.size() > 0) m_sum = m_sum ^ exp_q.pop_front();
        m_out++;
        ov_exp = 0;
        if (m_out == m_len) begin
          m_active = 0;
          done_exp = 1;
        end
      end
      if (st_exp) begin
        p_wait = 1;
        wcnt = 0;
      end
      st_exp = st_nx;
    end
  end

  // Output sink: always ready, random, or held low 5 cycles on the second output of a burst.
  bit rand_rdy = 0, bp_mode = 0;
  int bp_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode && out_valid && m_out == 1 && bp_cnt < 5) begin
        out_ready = 1'b0;
        bp_cnt++;
      end else begin
        out_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
    end
  end

  logic [7:0] pa[16], pb[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_accept(input int len);
    int g;
    g = 0;
    req_valid = 1'b1;
    req_len = 8'(len);
    @(negedge clk);
    while (!req_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_pairs(input int len);
    int k, g;
    k = 0;
    g = 0;
    while (k < len && g < 3000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_a      = pa[k];
      in_b      = pb[k];
      req_valid = ($urandom_range(0, 1) == 1);
      req_len   = 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) k++;
      tick();
      g++;
    end
    in_valid = 1'b0;
    req_valid = 1'b0;
    chk("pairs_accepted", 32'(k), 32'(len));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    @(negedge clk);
    while (!burst_done && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("burst_done_seen", 32'(burst_done), 32'(1));
    tick();
  endtask

  task automatic run_burst(input int len);
    req_accept(len);
    send_pairs(len);
    wait_done();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  int s_start, s_done, s_ov, len;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'(1));
    chk("reset_busy", 32'(busy), 32'(0));
    reset = 1'b0;
    tick();

    // Single pair: 0xA5 ^ 0x3C = 0x99.
    pa[0] = 8'hA5; pb[0] = 8'h3C;
    obs_q.delete(); s_start = n_start; s_done = n_done;
    run_burst(1);
    chk("t1_nout", 32'(obs_q.size()), 32'(1));
    if (obs_q.size() >= 1) chk("t1_out", 32'(obs_q[0]), 32'({1'b1, 8'h99}));
    chk("t1_sum", 32'(burst_checksum), 32'(8'h99));
    chk("t1_starts", 32'(n_start - s_start), 32'(1));
    chk("t1_done_pulses", 32'(n_done - s_done), 32'(1));

    // Burst of 3: 0xFF, 0x26, 0x00 -> checksum 0xD9.
    pa[0] = 8'hFF; pb[0] = 8'h00;
    pa[1] = 8'h12; pb[1] = 8'h34;
    pa[2] = 8'hAA; pb[2] = 8'hAA;
    obs_q.delete();
    run_burst(3);
    chk("t3_nout", 32'(obs_q.size()), 32'(3));
    if (obs_q.size() >= 3) begin
      chk("t3_out0", 32'(obs_q[0]), 32'({1'b0, 8'hFF}));
      chk("t3_out1", 32'(obs_q[1]), 32'({1'b0, 8'h26}));
      chk("t3_out2", 32'(obs_q[2]), 32'({1'b1, 8'h00}));
    end
    chk("t3_sum", 32'(burst_checksum), 32'(8'hD9));

    // Backpressure on pair 2.
    for (int i = 0; i < 3; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
    bp_mode = 1; bp_cnt = 0; s_start = n_start;
    run_burst(3);
    bp_mode = 0;
    chk("bp_hold_cycles", 32'(bp_cnt), 32'(5));
    chk("bp_starts", 32'(n_start - s_start), 32'(3));

    // Zero-length request.
    obs_q.delete(); s_start = n_start; s_done = n_done;
    run_burst(0);
    chk("z_starts", 32'(n_start - s_start), 32'(0));
    chk("z_done_pulses", 32'(n_done - s_done), 32'(1));
    chk("z_sum", 32'(burst_checksum), 32'(8'h00));
    chk("z_nout", 32'(obs_q.size()), 32'(0));

    // Reset while pair 2 of 3 is waiting on the datapath.
    dp_lat_fixed = 10;
    for (int i = 0; i < 3; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
    req_accept(3);
    send_pairs(2);
    tick();
    tick();
    chk("mid_busy", 32'(busy), 32'(1));
    s_done = n_done;
    reset = 1'b1;
    #1;
    chk("mid_rst_outs", 32'({out_valid, busy, dp_start, in_ready, out_last}), 32'(0));
    chk("mid_rst_ready", 32'(req_ready), 32'(1));
    chk("mid_rst_data", {dp_byte_a, dp_byte_b, out_parity, burst_checksum}, 32'(0));
    tick();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("mid_no_done", 32'(n_done - s_done), 32'(0));
    dp_lat_fixed = 1;
    pa[0] = 8'h0F; pb[0] = 8'hF0;
    obs_q.delete();
    run_burst(1);
    if (obs_q.size() >= 1) chk("post_rst_out", 32'(obs_q[0]), 32'({1'b1, 8'hFF}));
    chk("post_rst_nout", 32'(obs_q.size()), 32'(1));

    // Randomized bursts with random latency, backpressure and stray dp_done pulses.
    noise_en = 1; rand_rdy = 1; dp_lat_fixed = 0;
    for (int b = 0; b < 25; b++) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) begin pa[i] = 8'($urandom); pb[i] = 8'($urandom); end
      run_burst(len);
    end
    // Completion exactly on the terminal wait count.
    dp_lat_fixed = TO;
    pa[0] = 8'h81; pb[0] = 8'h18; pa[1] = 8'h55; pb[1] = 8'h0F;
    obs_q.delete();
    run_burst(2);
    chk("tc_nout", 32'(obs_q.size()), 32'(2));
    chk("tc_sum", 32'(burst_checksum), 32'(8'h99 ^ 8'h5A));

    // Datapath that never completes.
    noise_en = 0; rand_rdy = 0; dp_lat_fixed = 1; dp_hang = 1;
    pa[0] = 8'h3C; pb[0] = 8'hC3;
    s_ov = n_ov;
    req_accept(1);
    send_pairs(1);
`ifdef BPC_TIMEOUT_EN
    begin
      int g;
      g = 0;
      @(negedge clk);
      while (!burst_done && g < 40) begin
        @(negedge clk);
        g++;
      end
      chk("to_burst_done", 32'(burst_done), 32'(1));
      chk("to_latency", 32'(cyc - last_start_cyc), 32'(TO + 1));
      chk("to_err", 32'(err_timeout), 32'(1));
      tick();
      chk("to_idle", 32'(req_ready), 32'(1));
      chk("to_no_output", 32'(n_ov - s_ov), 32'(0));
      dp_hang = 0;
      run_burst(1);
      chk("to_err_cleared", 32'(err_timeout), 32'(0));
    end
`else
    repeat (100) tick();
    chk("hang_busy", 32'(busy), 32'(1));
    chk("hang_in_ready", 32'(in_ready), 32'(0));
    chk("hang_out_valid", 32'(out_valid), 32'(0));
    chk("hang_err", 32'(err_timeout), 32'(0));
    chk("hang_no_output", 32'(n_ov - s_ov), 32'(0));
    dp_hang = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/byte_parity_ctrl.md
Name: byte_parity_ctrl

Overview:
Sequencer for the byte_parity datapath. Accepts a burst request (N byte pairs) and, for each pair, loads the operands and pulses start. It then waits for done, returns the parity byte over a valid/ready output, and folds it into a running burst checksum. Sits between the stimulus/host interface and one byte_parity instance; it is the only driver of that instance's operand and start inputs.

Parameters:
DATA_WIDTH, 8, operand/parity width; must match the datapath instance
LEN_W, 8, width of burst length field (max burst 2^LEN_W-1 pairs)
TIMEOUT, 16, cycles in WAIT without dp_done before abort (used only with BPC_TIMEOUT_EN)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high; all state and outputs to reset values
req_valid  in  1  burst request valid
req_ready  out  1  high only in IDLE
req_len  in  LEN_W  number of pairs in burst
in_valid  in  1  operand pair valid
in_ready  out  1  high only in FETCH
in_a, in_b  in  DATA_WIDTH  operand pair
dp_byte_a, dp_byte_b  out  DATA_WIDTH  registered operands to datapath
dp_start  out  1  one-cycle start pulse to datapath
dp_done  in  1  datapath completion
dp_parity  in  DATA_WIDTH  datapath result, valid when dp_done
out_valid  out  1  result valid
out_ready  in  1  result accepted
out_parity  out  DATA_WIDTH  registered result
out_last  out  1  high with out_valid on final pair of burst
burst_done  out  1  one-cycle pulse at end of burst (normal or aborted)
burst_checksum  out  DATA_WIDTH  XOR of all accepted out_parity in current/last burst
err_timeout  out  1  sticky abort flag
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: every output 0 except req_ready=1 (IDLE). remaining=0, timer=0.
- States: IDLE, FETCH, START, WAIT, OUTPUT.
- IDLE: req_ready=1. On req_valid: clear burst_checksum and err_timeout; remaining<=req_len. If req_len=0, burst_done pulses next cycle and state stays IDLE. Otherwise go to FETCH.
- FETCH: in_ready=1. On in_valid&in_ready: dp_byte_a/b<=in_a/in_b, go to START.
- START: dp_start=1 for exactly this cycle. Go to WAIT. dp_done seen during START is ignored as stale.
- WAIT: dp_start=0. On dp_done: out_parity<=dp_parity, out_valid<=1, out_last<=(remaining==1), go to OUTPUT. Operands are held stable from START until leaving WAIT.
- OUTPUT: out_valid and out_parity hold until out_ready. On handshake: burst_checksum^=out_parity, remaining-=1, out_valid<=0. If remaining was 1, burst_done pulses next cycle and go to IDLE; else go to FETCH.
- Minimum per-pair latency with a 1-cycle datapath and always-ready out: 4 cycles from input accept to output accept.
- dp_done is sampled only in WAIT. Extra dp_done pulses in other states are ignored.
- req_valid is ignored while busy. in_valid is ignored outside FETCH.
- Asynchronous reset mid-burst: immediate return to IDLE with reset values. No burst_done is emitted.
- remaining never wraps: decrement occurs only on an output handshake with remaining>=1.

Optional Feature:
BPC_TIMEOUT_EN
- Defined: WAIT counts cycles from entry. If dp_done is absent for TIMEOUT consecutive cycles, the controller sets err_timeout (sticky until next request accept), pulses burst_done, produces no output for that pair, discards the rest of the burst, and returns to IDLE. dp_done arriving on the same cycle as the terminal count wins (normal completion).
- Not defined: no timer logic; WAIT waits indefinitely. err_timeout is tied to 0.

Decomposition:
- Shared package/include (byte_parity_pkg): state encoding localparams (IDLE=0..OUTPUT=4), DATA_WIDTH default, TIMEOUT default.
- One natural sub-module: bpc_timeout_timer (load/count/expire), instantiated only under BPC_TIMEOUT_EN.
- The datapath itself is instantiated by the parent, not inside this block.

Test Plan:
- Single pair: req_len=1, a=0xA5, b=0x3C, datapath done 1 cycle after start -> out_parity=0x99, out_last=1, burst_checksum=0x99, one burst_done pulse, dp_start high exactly 1 cycle.
- Burst of 3: pairs (0xFF,0x00), (0x12,0x34), (0xAA,0xAA) -> outputs 0xFF, 0x26, 0x00; out_last only on third; burst_checksum=0xD9.
- Backpressure: out_ready low 5 cycles on pair 2 -> out_valid/out_parity stable, in_ready low, no extra dp_start.
- Zero length: req_len=0 -> burst_done one cycle later, no dp_start, checksum 0x00, busy never high.
- Reset mid-WAIT: assert reset during pair 2 of 3 -> all outputs 0 immediately, req_ready=1, no burst_done. A new req_len=1 burst (0x0F,0xF0) then completes with 0xFF.
- Timeout (BPC_TIMEOUT_EN, TIMEOUT=16): datapath never asserts done -> err_timeout=1 and burst_done pulse 16 cycles after WAIT entry, out_valid never high, back in IDLE. Without the macro, the design is still in WAIT after 100 cycles.
